// File: rtl/onchip_mem_loader.sv
// onchip_mem_loader: packs a byte stream into 32-bit words, writes them to on-chip memory and optionally verifies by checksum
module onchip_mem_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 12265
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       byte_count,
  input  logic              verify_en,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [31:0]       checksum
);
  typedef enum logic [2:0] {IDLE, CHECK, FILL, WRITE, RD_ADDR, RD_CMP, DONE} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] base, addr;
  logic [15:0] count, remaining;
  logic verify;
  logic [1:0] lane, err_q;
  logic [3:0] mask, rd_mask;
  logic [31:0] word, sum_q, rsum, rd_add;
  logic [16:0] words;
  logic range_bad, last_rd;
  assign words = ({1'b0, count} + 17'd3) >> 2;
  assign range_bad = 17'(base) + words > 17'(DEPTH);
  assign last_rd = remaining == 16'd1;
  // only the final readback word can be partial
  assign rd_mask = (last_rd && count[1:0] != 2'd0) ? (4'd1 << count[1:0]) - 4'd1 : 4'hF;
  assign rd_add = (rd_mask[0] ? 32'(mem_readdata[7:0])   : 32'd0)
                + (rd_mask[1] ? 32'(mem_readdata[15:8])  : 32'd0)
                + (rd_mask[2] ? 32'(mem_readdata[23:16]) : 32'd0)
                + (rd_mask[3] ? 32'(mem_readdata[31:24]) : 32'd0);
  assign in_ready = state == FILL;
  assign mem_chipselect = state == WRITE || state == RD_ADDR;
  assign mem_write = state == WRITE;
  assign mem_byteenable = state == WRITE ? mask : state == RD_ADDR ? 4'hF : 4'h0;
  assign mem_address = addr;
  assign mem_writedata = word;
  assign mem_clken = 1'b1;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign err_code = err_q;
  assign error = err_q != 2'd0;
  assign checksum = sum_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? CHECK : IDLE;
      CHECK:   next = (count == 16'd0 || range_bad) ? DONE : FILL;
      FILL:    next = (in_valid && (lane == 2'd3 || remaining == 16'd1)) ? WRITE : FILL;
      WRITE:   next = remaining != 16'd0 ? FILL : verify ? RD_ADDR : DONE;
      RD_ADDR: next = RD_CMP;
      RD_CMP:  next = last_rd ? DONE : RD_ADDR;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      base <= '0;
      addr <= '0;
      count <= '0;
      remaining <= '0;
      verify <= 1'b0;
      lane <= '0;
      err_q <= '0;
      mask <= '0;
      word <= '0;
      sum_q <= '0;
      rsum <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          count <= byte_count;
          verify <= verify_en;
          sum_q <= '0;
          err_q <= '0;
        end
        CHECK: begin
          lane <= '0;
          mask <= '0;
          addr <= base;
          remaining <= count;
          if (count != 16'd0 && range_bad) err_q <= 2'd1;
        end
        FILL: if (in_valid) begin
          // lane 0 starts a fresh word so unfilled lanes read as zero
          word <= (lane == 2'd0 ? 32'd0 : word) | (32'(in_data) << {lane, 3'b000});
          mask <= mask | (4'd1 << lane);
          sum_q <= sum_q + 32'(in_data);
          lane <= lane + 2'd1;
          remaining <= remaining - 16'd1;
        end
        WRITE: begin
          mask <= '0;
          lane <= '0;
          if (remaining != 16'd0) addr <= addr + 1'b1;
          else if (verify) begin
            addr <= base;
            rsum <= '0;
            remaining <= words[15:0];
          end
        end
        RD_CMP: begin
          rsum <= rsum + rd_add;
          if (!last_rd) begin
            addr <= addr + 1'b1;
            remaining <= remaining - 16'd1;
          end else if (rsum + rd_add != sum_q) err_q <= 2'd2;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_onchip_mem_loader.sv
// tb_onchip_mem_loader: directed vector table plus reset and busy-start sequences against a memory model
module tb_onchip_mem_loader;
  localparam int AW = 14;
  localparam int DEPTH = 12265;
  logic clk = 0, reset_n = 0, start = 0, verify_en = 0, in_valid = 0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0] byte_count = '0;
  logic [7:0] in_data = '0;
  logic in_ready, mem_chipselect, mem_write, mem_clken, busy, done, error;
  logic [AW-1:0] mem_address;
  logic [3:0] mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata, checksum;
  logic [1:0] err_code;
  int nvec = 0, nmis = 0;
  always #5 clk = ~clk;
  onchip_mem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .verify_en(verify_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .checksum(checksum)
  );
  // memory: registered address, combinational read data, optional fault on word 0x11 lane 2
  logic [31:0] mem [0:DEPTH-1];
  logic [AW-1:0] rd_addr = '0, lw_addr = '0;
  logic [31:0] lw_data = '0;
  logic [3:0] lw_be = '0;
  logic corrupt = 0, prev_cs = 0, prev_wr = 0;
  int wr_n = 0, rd_n = 0, viol = 0;
  assign mem_readdata = mem[rd_addr] ^ ((corrupt && rd_addr == 14'h011) ? 32'h00FF0000 : 32'h0);
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5A5A5;
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int k = 0; k < 4; k++)
        if (mem_byteenable[k]) mem[mem_address][8*k +: 8] = mem_writedata[8*k +: 8];
      wr_n <= wr_n + 1;
      lw_addr <= mem_address;
      lw_data <= mem_writedata;
      lw_be <= mem_byteenable;
    end
    if (mem_chipselect && !mem_write) begin
      rd_n <= rd_n + 1;
      rd_addr <= mem_address;
    end
    if ((in_ready && mem_chipselect) || (mem_byteenable != 4'h0 && !mem_chipselect) ||
        (prev_cs && mem_chipselect && !(prev_wr && !mem_write)))
      viol <= viol + 1;
    prev_cs <= mem_chipselect;
    prev_wr <= mem_write;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_reset(input string t);
    chk({t, "_in_ready"}, 32'(in_ready), 0);
    chk({t, "_busy_done"}, {30'd0, busy, done}, 0);
    chk({t, "_error"}, {29'd0, error, err_code}, 0);
    chk({t, "_checksum"}, checksum, 0);
    chk({t, "_mem_ctl"}, {26'd0, mem_chipselect, mem_write, mem_byteenable}, 0);
    chk({t, "_mem_addr"}, 32'(mem_address), 0);
    chk({t, "_mem_wdata"}, mem_writedata, 0);
    chk({t, "_clken"}, 32'(mem_clken), 1);
  endtask
  typedef struct {
    logic [13:0] base; logic [15:0] cnt; logic ver, cor, gap, poke;
    logic [7:0] b0, step; int wr, rd; logic [1:0] err;
    logic [31:0] csum, ldata; logic [3:0] lbe; logic [13:0] laddr;
  } vec_t;
  vec_t vt [9];
  task automatic run(input vec_t v, input int k);
    int idx = 0, cyc = 0, w0 = wr_n, r0 = rd_n, v0 = viol;
    logic seen = 0;
    corrupt = v.cor;
    @(negedge clk);
    base_addr = v.base; byte_count = v.cnt; verify_en = v.ver; start = 1;
    @(negedge clk);
    start = 0;
    while (!seen && cyc < 300) begin
      if (done) seen = 1;
      else begin
        if (v.poke) begin
          start = cyc == 3; base_addr = 14'h030; byte_count = 16'd100;
        end
        in_valid = idx < int'(v.cnt) && (!v.gap || cyc % 2 == 1);
        in_data = v.b0 + 8'(idx) * v.step;
        if (in_valid && in_ready) idx++;
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 0; start = 0;
    chk($sformatf("v%0d_done_seen", k), 32'(seen), 1);
    chk($sformatf("v%0d_err_code", k), 32'(err_code), 32'(v.err));
    chk($sformatf("v%0d_error", k), 32'(error), 32'(v.err != 0));
    chk($sformatf("v%0d_checksum", k), checksum, v.csum);
    chk($sformatf("v%0d_busy", k), 32'(busy), 0);
    chk($sformatf("v%0d_writes", k), wr_n - w0, v.wr);
    chk($sformatf("v%0d_reads", k), rd_n - r0, v.rd);
    chk($sformatf("v%0d_bytes", k), idx, v.wr == 0 ? 0 : int'(v.cnt));
    chk($sformatf("v%0d_strobe_rules", k), viol - v0, 0);
    if (v.wr > 0) begin
      chk($sformatf("v%0d_last_addr", k), 32'(lw_addr), 32'(v.laddr));
      chk($sformatf("v%0d_last_data", k), lw_data, v.ldata);
      chk($sformatf("v%0d_last_be", k), 32'(lw_be), 32'(v.lbe));
    end else chk($sformatf("v%0d_done_latency", k), 32'(cyc <= 3), 1);
    if (v.rd > 0) chk($sformatf("v%0d_last_rd_addr", k), 32'(rd_addr), 32'(v.laddr));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", k), 32'(done), 0);
    chk($sformatf("v%0d_error_held", k), {30'd0, error, 1'b0} | 32'(err_code), {30'd0, v.err != 0, 1'b0} | 32'(v.err));
    chk($sformatf("v%0d_checksum_held", k), checksum, v.csum);
  endtask
  initial begin
    int idx, lim;
    vt[0] = '{14'h010, 16'd8, 0, 0, 0, 0, 8'h01, 8'h01, 2, 0, 2'd0, 32'h24,  32'h08070605, 4'hF, 14'h011};
    vt[1] = '{14'h000, 16'd6, 0, 0, 1, 0, 8'hAA, 8'h11, 2, 0, 2'd0, 32'h4FB, 32'h0000FFEE, 4'h3, 14'h001};
    vt[2] = '{14'd12264, 16'd5, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0, 2'd1, 32'h0, 32'h0, 4'h0, 14'h0};
    vt[3] = '{14'h010, 16'd8, 1, 1, 0, 0, 8'h01, 8'h01, 2, 2, 2'd2, 32'h24,  32'h08070605, 4'hF, 14'h011};
    vt[4] = '{14'h010, 16'd8, 1, 0, 0, 0, 8'h01, 8'h01, 2, 2, 2'd0, 32'h24,  32'h08070605, 4'hF, 14'h011};
    vt[5] = '{14'h005, 16'd0, 1, 0, 0, 0, 8'h01, 8'h01, 0, 0, 2'd0, 32'h0, 32'h0, 4'h0, 14'h0};
    vt[6] = '{14'd12263, 16'd8, 1, 0, 0, 0, 8'h10, 8'h01, 2, 2, 2'd0, 32'h9C, 32'h17161514, 4'hF, 14'd12264};
    vt[7] = '{14'h100, 16'd5, 1, 0, 0, 0, 8'hF0, 8'h01, 2, 2, 2'd0, 32'h4BA, 32'h000000F4, 4'h1, 14'h101};
    vt[8] = '{14'h020, 16'd4, 0, 0, 0, 1, 8'h40, 8'h01, 1, 0, 2'd0, 32'h106, 32'h43424140, 4'hF, 14'h020};
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < 9; k++) run(vt[k], k);
    // reset three bytes into a word: nothing may reach memory
    idx = wr_n;
    @(negedge clk);
    base_addr = 14'h040; byte_count = 16'd8; verify_en = 0; start = 1;
    @(negedge clk);
    start = 0; lim = 0;
    while (idx - wr_n < 3 && lim < 50) begin
      in_valid = 1;
      in_data = 8'h90 + 8'(idx - wr_n);
      if (in_ready) idx++;
      @(negedge clk);
      lim++;
    end
    idx = idx - 3;
    in_valid = 0; reset_n = 0;
    #1 chk_reset("midrst");
    chk("midrst_no_write", wr_n - idx, 0);
    chk("midrst_mem_untouched", mem[14'h040], 32'hA5A5A5A5);
    @(negedge clk);
    reset_n = 1;
    run(vt[0], 9);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
